board_ctrl: RTL and testbench

BOARD_CTRL -- requirements
Module: board_ctrl

---
 rtl/board_pkg.sv | 33 +++
 rtl/board_arbiter.sv | 50 +++++
 rtl/board_ctrl.sv | 161 ++++++++++++++++
 tb/tb_board_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the board controller and the pixel generator:
// board geometry, cell encodings and the move-engine state enum.
package board_pkg;

  localparam logic [11:0] BOARD_BASE_ADDR = 12'h400;
  localparam int          BOARD_ROWS      = 6;
  localparam int          BOARD_COLS      = 7;

  localparam logic [15:0] CELL_EMPTY = 16'd0;
  localparam logic [15:0] CELL_P1    = 16'd1;
  localparam logic [15:0] CELL_P2    = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CHK,
    ST_WR,
    ST_CLR,
    ST_DONE
  } state_t;

  // Rows are 8 words apart, so the in-board offset is simply {row, col}.
  function automatic logic [11:0] cell_addr(input logic [11:0] base,
                                            input logic [2:0]  row,
                                            input logic [2:0]  col);
    return base + {6'd0, row, col};
  endfunction

  function automatic logic [15:0] player_cell(input logic turn);
    return turn ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/board_arbiter.sv
// Fixed-priority board RAM mux: the display port always wins, the move
// engine gets the port otherwise. Also produces the display read ack.
module board_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_req,
  input  logic [11:0] disp_addr,
  output logic [15:0] disp_data,
  output logic        disp_ack,
  input  logic        eng_req,
  input  logic [11:0] eng_addr,
  input  logic        eng_we,
  input  logic [15:0] eng_wdata,
  output logic        eng_grant,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    eng_grant = 1'b0;
    if (!reset) begin
      if (disp_req) begin
        mem_addr = disp_addr;
      end else if (eng_req) begin
        eng_grant = 1'b1;
        mem_addr  = eng_addr;
        mem_we    = eng_we;
        mem_wdata = eng_wdata;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) disp_ack <= 1'b0;
    else       disp_ack <= disp_req;
  end

  // RAM read latency is one cycle, so the data lines up with disp_ack.
  assign disp_data = mem_rdata;

endmodule

// File: rtl/board_ctrl.sv
// Board controller: drops pieces into the lowest empty cell of a column,
// clears the board on request, and shares the board RAM with the display.
module board_ctrl
  import board_pkg::*;
#(
  parameter logic [11:0] BOARD_BASE = BOARD_BASE_ADDR,
  parameter int          ROWS       = BOARD_ROWS,
  parameter int          COLS       = BOARD_COLS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_valid,
  input  logic [2:0]  move_col,
  output logic        move_ready,
  output logic        move_done,
  output logic        move_ok,
  input  logic        clear_req,
  input  logic        disp_req,
  input  logic [11:0] disp_addr,
  output logic [15:0] disp_data,
  output logic        disp_ack,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        turn,
  output logic        board_full
);

  localparam logic [5:0] CELLS    = 6'(ROWS * COLS);
  localparam logic [3:0] NCOLS    = 4'(COLS);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  state_t      state, state_n;
  logic [2:0]  row, row_n, col, col_n;
  logic [5:0]  count, count_n;
  logic        turn_n, ok, ok_n;
  logic        rd_valid;
  logic        mem_state, eng_req, eng_we, eng_grant;
  logic [11:0] eng_addr;
  logic [15:0] eng_wdata;

  assign mem_state  = (state == ST_RD) || (state == ST_CHK) ||
                      (state == ST_WR) || (state == ST_CLR);
  // A clear in flight suppresses the engine's access that cycle.
  assign eng_req    = mem_state && !clear_req;
  assign eng_addr   = cell_addr(BOARD_BASE, row, col);
  assign eng_we     = (state == ST_WR) || (state == ST_CLR);
  assign eng_wdata  = (state == ST_WR) ? player_cell(turn) : CELL_EMPTY;

  assign move_ready = (state == ST_IDLE) && !clear_req;
  assign move_done  = (state == ST_DONE);
  assign move_ok    = (state == ST_DONE) && ok;
  assign board_full = (count == CELLS);

  board_arbiter u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_ack  (disp_ack),
    .eng_req   (eng_req),
    .eng_addr  (eng_addr),
    .eng_we    (eng_we),
    .eng_wdata (eng_wdata),
    .eng_grant (eng_grant),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    turn_n  = turn;
    count_n = count;
    ok_n    = ok;
    if (clear_req) begin
      state_n = ST_CLR;
      row_n   = 3'd0;
      col_n   = 3'd0;
    end else begin
      unique case (state)
        ST_IDLE: if (move_valid) begin
          if (({1'b0, move_col} >= NCOLS) || board_full) begin
            ok_n    = 1'b0;
            state_n = ST_DONE;
          end else begin
            col_n   = move_col;
            row_n   = LAST_ROW;
            state_n = ST_RD;
          end
        end
        ST_RD: if (eng_grant) state_n = ST_CHK;
        // rdata belongs to us only right after a granted read; otherwise
        // this cycle re-issues the read and the data is taken next cycle.
        ST_CHK: if (eng_grant && rd_valid) begin
          if (mem_rdata == CELL_EMPTY) begin
            state_n = ST_WR;
          end else if (row == 3'd0) begin
            ok_n    = 1'b0;
            state_n = ST_DONE;
          end else begin
            row_n   = row - 3'd1;
            state_n = ST_RD;
          end
        end
        ST_WR: if (eng_grant) begin
          count_n = (count == CELLS) ? count : count + 6'd1;
          turn_n  = !turn;
          ok_n    = 1'b1;
          state_n = ST_DONE;
        end
        ST_CLR: if (eng_grant) begin
          if (col == LAST_COL) begin
            col_n = 3'd0;
            if (row == LAST_ROW) begin
              count_n = '0;
              turn_n  = 1'b0;
              ok_n    = 1'b1;
              state_n = ST_DONE;
            end else begin
              row_n = row + 3'd1;
            end
          end else begin
            col_n = col + 3'd1;
          end
        end
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // NOTE: only the engine's control state is reset; the board RAM is
  // external and keeps its contents until software issues clear_req.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      row      <= '0;
      col      <= '0;
      turn     <= 1'b0;
      count    <= '0;
      ok       <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      turn     <= turn_n;
      count    <= count_n;
      ok       <= ok_n;
      rd_valid <= eng_grant && ((state == ST_RD) || (state == ST_CHK));
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl: a behavioural RAM, a write monitor and
// a cell-level game model that predicts every move outcome and write.
module tb_board_ctrl;
  import board_pkg::*;

  logic        clk, reset;
  logic        move_valid, move_ready, move_done, move_ok;
  logic [2:0]  move_col;
  logic        clear_req, disp_req, disp_ack;
  logic [11:0] disp_addr, mem_addr;
  logic [15:0] disp_data, mem_wdata, mem_rdata;
  logic        mem_we, turn, board_full;

  int errors, checks;

  board_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .move_valid (move_valid),
    .move_col   (move_col),
    .move_ready (move_ready),
    .move_done  (move_done),
    .move_ok    (move_ok),
    .clear_req  (clear_req),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_ack   (disp_ack),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .turn       (turn),
    .board_full (board_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM with one-cycle read latency, plus an access log.
  typedef struct { logic [11:0] addr; logic [15:0] data; } wr_t;
  logic [15:0] ram [0:4095];
  wr_t         wlog [$];
  int          eng_acc;
  logic [11:0] first_rd;
  bit          rd_seen;

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] = mem_wdata;
      wlog.push_back(wr_t'{mem_addr, mem_wdata});
    end
    if (!disp_req && mem_addr != 12'd0) begin
      eng_acc++;
      if (!mem_we && !rd_seen) begin
        first_rd = mem_addr;
        rd_seen  = 1'b1;
      end
    end
  end

  // Game model: lowest empty cell of the column, alternating players.
  int mboard [0:BOARD_ROWS-1][0:BOARD_COLS-1];
  int mturn, mcount;

  function automatic void model_clear();
    for (int r = 0; r < BOARD_ROWS; r++)
      for (int c = 0; c < BOARD_COLS; c++) mboard[r][c] = 0;
    mturn  = 0;
    mcount = 0;
  endfunction

  function automatic void model_move(input int col, output bit ok, output int addr, output int data);
    ok = 1'b0; addr = 0; data = 0;
    if (col >= BOARD_COLS || mcount == BOARD_ROWS * BOARD_COLS) return;
    for (int r = BOARD_ROWS - 1; r >= 0; r--) begin
      if (mboard[r][col] == 0) begin
        data          = mturn + 1;
        mboard[r][col] = data;
        addr          = int'(BOARD_BASE_ADDR) + r * 8 + col;
        ok            = 1'b1;
        mturn         = 1 - mturn;
        mcount++;
        return;
      end
    end
  endfunction

  // Issue one move and wait for its completion pulse (bounded).
  task automatic do_move(input int col, input bit noise, output bit ok, output bit done,
                         output int lat, output bit pulse_hi);
    bit accepted;
    int acc_cyc;
    wlog.delete(); eng_acc = 0; rd_seen = 1'b0;
    accepted = 1'b0; done = 1'b0; ok = 1'b0; lat = 0; acc_cyc = 0;
    @(negedge clk);
    move_valid = 1'b1;
    move_col   = 3'(col);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      disp_req  = noise && ($urandom_range(0, 3) == 0);
      disp_addr = 12'($urandom);
      #1;
      if (move_done) begin done = 1'b1; ok = move_ok; lat = cyc - acc_cyc; end
      if (!accepted && move_valid && move_ready) begin accepted = 1'b1; acc_cyc = cyc; end
      @(negedge clk);
      if (accepted) move_valid = 1'b0;
    end
    disp_req = 1'b0;
    #1 pulse_hi = move_done;
  endtask

  task automatic do_clear();
    bit done;
    done = 1'b0;
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      #1 if (move_done) done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!done) begin errors++; $display("FAIL clear_timeout: no move_done within 200 cycles"); end
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; disp_req = 1'b1; disp_addr = 12'h123;
    move_valid = 1'b1; move_col = 3'd3; clear_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mem_addr !== 12'd0 || mem_we !== 1'b0 || mem_wdata !== 16'd0) begin
      errors++; $display("FAIL reset_mem: addr=%h we=%b wdata=%h, expected all zero", mem_addr, mem_we, mem_wdata);
    end
    checks++;
    if (disp_ack !== 1'b0 || move_done !== 1'b0 || move_ok !== 1'b0 || turn !== 1'b0) begin
      errors++; $display("FAIL reset_out: ack=%b done=%b ok=%b turn=%b, expected 0", disp_ack, move_done, move_ok, turn);
    end
    @(negedge clk);
    reset = 1'b0; disp_req = 1'b0; move_valid = 1'b0;
    #1;
    checks++;
    if (move_ready !== 1'b1 || board_full !== 1'b0) begin
      errors++; $display("FAIL reset_idle: ready=%b full=%b, expected 1/0", move_ready, board_full);
    end
  endtask

  // Clear restarted part-way through under display traffic.
  task automatic test_clear();
    int done_cnt, gap, bad;
    bit ok_seen;
    done_cnt = 0; ok_seen = 1'b0; bad = 0;
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    gap = $urandom_range(5, 30);
    for (int i = 0; i < gap; i++) begin
      disp_req = ($urandom_range(0, 3) == 0); disp_addr = 12'($urandom);
      #1 if (move_done) done_cnt++;
      @(negedge clk);
    end
    disp_req = 1'b0; clear_req = 1'b1; wlog.delete();
    @(negedge clk); clear_req = 1'b0;
    for (int i = 0; i < 150; i++) begin
      disp_req = ($urandom_range(0, 3) == 0); disp_addr = 12'($urandom);
      #1 if (move_done) begin done_cnt++; ok_seen = move_ok; end
      @(negedge clk);
    end
    disp_req = 1'b0;
    for (int k = 0; k < wlog.size(); k++)
      if (wlog[k].addr !== 12'(int'(BOARD_BASE_ADDR) + (k / 7) * 8 + k % 7) || wlog[k].data !== 16'd0) bad++;
    checks++;
    if (done_cnt != 1 || ok_seen !== 1'b1) begin
      errors++; $display("FAIL clear_done: pulses=%0d ok=%b, expected 1 pulse with ok=1", done_cnt, ok_seen);
    end
    checks++;
    if (wlog.size() != 42 || bad != 0) begin
      errors++; $display("FAIL clear_sweep: %0d writes, %0d out of order or nonzero, expected 42 row-major zeros", wlog.size(), bad);
    end
    #1;
    checks++;
    if (turn !== 1'b0 || board_full !== 1'b0) begin
      errors++; $display("FAIL clear_state: turn=%b full=%b, expected 0/0", turn, board_full);
    end
    model_clear();
  endtask

  task automatic test_first_move();
    bit ok, done, ph, e_ok;
    int lat, e_addr, e_data;
    model_move(3, e_ok, e_addr, e_data);
    do_move(3, 1'b0, ok, done, lat, ph);
    checks++;
    if (!rd_seen || first_rd !== 12'h42B) begin
      errors++; $display("FAIL first_read: addr=%h, expected 42b", first_rd);
    end
    checks++;
    if (wlog.size() != 1 || wlog[0].addr !== 12'h42B || wlog[0].data !== 16'd1) begin
      errors++; $display("FAIL first_write: %0d writes, expected one write of 1 to 42b", wlog.size());
    end
    checks++;
    if (!done || ok !== 1'b1 || turn !== 1'b1) begin
      errors++; $display("FAIL first_result: done=%b ok=%b turn=%b, expected 1/1/1", done, ok, turn);
    end
    checks++;
    if (ph !== 1'b0) begin errors++; $display("FAIL done_pulse: move_done still %b a cycle later, expected 0", ph); end
  endtask

  task automatic test_column_full();
    bit ok, done, ph, e_ok;
    int lat, e_addr, e_data;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      model_move(0, e_ok, e_addr, e_data);
      do_move(0, 1'b1, ok, done, lat, ph);
      checks++;
      if (!done || ok !== e_ok) begin
        errors++; $display("FAIL colfull_ok[%0d]: ok=%b done=%b, expected ok=%b", i, ok, done, e_ok);
      end
      checks++;
      if (e_ok ? (wlog.size() != 1 || wlog[0].addr !== 12'(e_addr) || wlog[0].data !== 16'(e_data)) : (wlog.size() != 0)) begin
        errors++; $display("FAIL colfull_write[%0d]: %0d writes, expected %0d to %h data %0d", i, wlog.size(), e_ok, e_addr, e_data);
      end
      checks++;
      if (turn !== 1'(mturn)) begin errors++; $display("FAIL colfull_turn[%0d]: turn=%b, expected %0d", i, turn, mturn); end
    end
  endtask

  task automatic test_bad_col();
    bit ok, done, ph;
    int lat;
    do_move(7, 1'b0, ok, done, lat, ph);
    checks++;
    if (!done || ok !== 1'b0 || lat > 2) begin
      errors++; $display("FAIL bad_col: done=%b ok=%b latency=%0d, expected done, ok=0, latency<=2", done, ok, lat);
    end
    checks++;
    if (eng_acc != 0 || wlog.size() != 0) begin
      errors++; $display("FAIL bad_col_ram: %0d engine accesses, %0d writes, expected none", eng_acc, wlog.size());
    end
  endtask

  // Display holds the port for 10 cycles while the engine sits in its read.
  task automatic test_disp_stall();
    bit e_ok, done, ok;
    int e_addr, e_data, bad;
    logic [15:0] exp_data;
    do_clear();
    model_move(2, e_ok, e_addr, e_data);
    wlog.delete(); bad = 0; done = 1'b0; ok = 1'b0; exp_data = '0;
    @(negedge clk); move_valid = 1'b1; move_col = 3'd2;
    #1;
    checks++;
    if (move_ready !== 1'b1) begin errors++; $display("FAIL stall_ready: ready=%b, expected 1", move_ready); end
    @(negedge clk); move_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = 12'h100 + 12'(i);
      #1;
      if (mem_addr !== disp_addr || mem_we !== 1'b0) bad++;
      if (i > 0 && (disp_ack !== 1'b1 || disp_data !== exp_data)) bad++;
      exp_data = ram[disp_addr];
      @(negedge clk);
    end
    disp_req = 1'b0;
    #1;
    checks++;
    if (bad != 0 || disp_ack !== 1'b1 || disp_data !== exp_data) begin
      errors++; $display("FAIL stall_disp: %0d bad cycles, last ack=%b data=%h, expected ack=1 data=%h", bad, disp_ack, disp_data, exp_data);
    end
    checks++;
    if (wlog.size() != 0) begin errors++; $display("FAIL stall_hold: %0d writes during stall, expected 0", wlog.size()); end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1 if (move_done) begin done = 1'b1; ok = move_ok; end
    end
    checks++;
    if (!done || ok !== e_ok || wlog.size() != 1 || wlog[0].addr !== 12'(e_addr) || wlog[0].data !== 16'(e_data)) begin
      errors++; $display("FAIL stall_move: done=%b ok=%b writes=%0d, expected ok=%b write %h=%0d", done, ok, wlog.size(), e_ok, e_addr, e_data);
    end
  endtask

  task automatic test_clear_during_wr();
    bit hit, ok_seen, ok, done, ph, e_ok;
    int done_cnt, bad, lat, e_addr, e_data;
    do_clear();
    hit = 1'b0; ok_seen = 1'b0; done_cnt = 0; bad = 0;
    @(negedge clk); move_valid = 1'b1; move_col = 3'd4;
    @(negedge clk); move_valid = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      #1;
      if (mem_we) begin hit = 1'b1; clear_req = 1'b1; wlog.delete(); end
      else @(negedge clk);
    end
    @(negedge clk); clear_req = 1'b0;
    for (int i = 0; i < 70; i++) begin
      #1 if (move_done) begin done_cnt++; ok_seen = move_ok; end
      @(negedge clk);
    end
    foreach (wlog[k]) if (wlog[k].data !== 16'd0) bad++;
    checks++;
    if (!hit) begin errors++; $display("FAIL clrwr_reach: write state not seen within 20 cycles"); end
    checks++;
    if (done_cnt != 1 || ok_seen !== 1'b1) begin
      errors++; $display("FAIL clrwr_done: pulses=%0d ok=%b, expected 1 pulse with ok=1", done_cnt, ok_seen);
    end
    checks++;
    if (wlog.size() != 42 || bad != 0) begin
      errors++; $display("FAIL clrwr_writes: %0d writes, %0d nonzero, expected 42 zero writes", wlog.size(), bad);
    end
    checks++;
    if (turn !== 1'b0 || board_full !== 1'b0) begin
      errors++; $display("FAIL clrwr_state: turn=%b full=%b, expected 0/0", turn, board_full);
    end
    model_clear();
    model_move(4, e_ok, e_addr, e_data);
    do_move(4, 1'b0, ok, done, lat, ph);
    checks++;
    if (!done || ok !== e_ok || wlog.size() != 1 || wlog[0].addr !== 12'(e_addr) || wlog[0].data !== 16'(e_data)) begin
      errors++; $display("FAIL clrwr_next: ok=%b writes=%0d, expected write %h=%0d", ok, wlog.size(), e_addr, e_data);
    end
  endtask

  task automatic test_random_game();
    bit ok, done, ph, e_ok;
    int lat, e_addr, e_data, col, bad;
    do_clear();
    for (int i = 0; i < 50; i++) begin
      col = $urandom_range(0, 7);
      model_move(col, e_ok, e_addr, e_data);
      do_move(col, 1'b1, ok, done, lat, ph);
      checks++;
      if (!done || ok !== e_ok) begin
        errors++; $display("FAIL rand_ok[%0d]: col=%0d ok=%b done=%b, expected ok=%b", i, col, ok, done, e_ok);
      end
      checks++;
      if (e_ok ? (wlog.size() != 1 || wlog[0].addr !== 12'(e_addr) || wlog[0].data !== 16'(e_data)) : (wlog.size() != 0)) begin
        errors++; $display("FAIL rand_write[%0d]: %0d writes, expected %0d to %h data %0d", i, wlog.size(), e_ok, e_addr, e_data);
      end
      checks++;
      if (turn !== 1'(mturn) || board_full !== (mcount == 42)) begin
        errors++; $display("FAIL rand_state[%0d]: turn=%b full=%b, expected %0d/%0b", i, turn, board_full, mturn, mcount == 42);
      end
    end
    bad = 0;
    for (int r = 0; r < BOARD_ROWS; r++)
      for (int c = 0; c < BOARD_COLS; c++)
        if (ram[int'(BOARD_BASE_ADDR) + r * 8 + c] !== 16'(mboard[r][c])) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_board: %0d cells differ from model, expected 0", bad); end
  endtask

  task automatic test_board_full();
    bit ok, done, ph, e_ok;
    int lat, e_addr, e_data, bad;
    do_clear();
    bad = 0;
    for (int i = 0; i < 42; i++) begin
      model_move(i % 7, e_ok, e_addr, e_data);
      do_move(i % 7, 1'b1, ok, done, lat, ph);
      if (!done || ok !== e_ok || wlog.size() != 1 || wlog[0].addr !== 12'(e_addr) || wlog[0].data !== 16'(e_data)) bad++;
    end
    checks++;
    if (bad != 0 || board_full !== 1'b1) begin
      errors++; $display("FAIL full_fill: %0d bad moves, full=%b, expected 0 bad and full=1", bad, board_full);
    end
    for (int i = 0; i < 2; i++) begin
      do_move(3, 1'b0, ok, done, lat, ph);
      checks++;
      if (!done || ok !== 1'b0 || wlog.size() != 0 || board_full !== 1'b1) begin
        errors++; $display("FAIL full_reject[%0d]: ok=%b writes=%0d full=%b, expected 0/0/1", i, ok, wlog.size(), board_full);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit, done_any, ok, done, ph, e_ok;
    int lat, e_addr, e_data;
    do_clear();
    model_move(1, e_ok, e_addr, e_data);
    do_move(1, 1'b0, ok, done, lat, ph);
    hit = 1'b0; done_any = 1'b0;
    @(negedge clk); move_valid = 1'b1; move_col = 3'd5;
    @(negedge clk); move_valid = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      #1;
      if (mem_we) begin hit = 1'b1; reset = 1'b1; wlog.delete(); end
      else @(negedge clk);
    end
    @(negedge clk);
    #1 if (move_done) done_any = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 if (move_done) done_any = 1'b1;
      @(negedge clk);
    end
    #1;
    checks++;
    if (!hit || wlog.size() != 0 || done_any) begin
      errors++; $display("FAIL rstmid_abort: reached=%b writes=%0d pulse=%b, expected 1/0/0", hit, wlog.size(), done_any);
    end
    checks++;
    if (turn !== 1'b0 || move_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state: turn=%b ready=%b, expected 0/1", turn, move_ready);
    end
    mturn = 0; mcount = 0;
    model_move(5, e_ok, e_addr, e_data);
    do_move(5, 1'b0, ok, done, lat, ph);
    checks++;
    if (!done || ok !== e_ok || wlog.size() != 1 || wlog[0].addr !== 12'(e_addr) || wlog[0].data !== 16'(e_data)) begin
      errors++; $display("FAIL rstmid_next: ok=%b writes=%0d, expected write %h=%0d", ok, wlog.size(), e_addr, e_data);
    end
  endtask

  initial begin
    errors = 0; checks = 0; eng_acc = 0; rd_seen = 1'b0; first_rd = '0;
    for (int a = 0; a < 4096; a++) ram[a] = 16'($urandom);
    model_clear();
    test_reset();
    test_clear();
    test_first_move();
    test_column_full();
    test_bad_col();
    test_disp_stall();
    test_clear_during_wr();
    test_random_game();
    test_board_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
